// File: rtl/inst_encoder_pkg.sv
// Shared opcodes, format classes, error codes and field bundle for the program-loader encoder.
package inst_encoder_pkg;

  localparam int unsigned OP_W   = 5;
  localparam int unsigned REG_W  = 3;
  localparam int unsigned IMM_W  = 8;
  localparam int unsigned INST_W = 16;
  localparam int unsigned ERR_W  = 2;

  // MoonCore opcodes
  localparam logic [OP_W-1:0] OP_ADD  = 5'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 5'd1;
  localparam logic [OP_W-1:0] OP_MUL  = 5'd2;
  localparam logic [OP_W-1:0] OP_AND  = 5'd3;
  localparam logic [OP_W-1:0] OP_OR   = 5'd4;
  localparam logic [OP_W-1:0] OP_XOR  = 5'd5;
  localparam logic [OP_W-1:0] OP_SLL  = 5'd6;
  localparam logic [OP_W-1:0] OP_SRL  = 5'd7;
  localparam logic [OP_W-1:0] OP_BEQ  = 5'd8;
  localparam logic [OP_W-1:0] OP_BLE  = 5'd9;
  localparam logic [OP_W-1:0] OP_ADDI = 5'd10;
  localparam logic [OP_W-1:0] OP_SUBI = 5'd11;
  localparam logic [OP_W-1:0] OP_MULI = 5'd12;
  localparam logic [OP_W-1:0] OP_ANDI = 5'd13;
  localparam logic [OP_W-1:0] OP_ORI  = 5'd14;
  localparam logic [OP_W-1:0] OP_XORI = 5'd15;
  localparam logic [OP_W-1:0] OP_SLLI = 5'd16;
  localparam logic [OP_W-1:0] OP_SRLI = 5'd17;
  localparam logic [OP_W-1:0] OP_LW   = 5'd18;
  localparam logic [OP_W-1:0] OP_SW   = 5'd19;
  localparam logic [OP_W-1:0] OP_CSRR = 5'd20;
  localparam logic [OP_W-1:0] OP_CSRW = 5'd21;
  localparam logic [OP_W-1:0] OP_JAL  = 5'd22;
  localparam logic [OP_W-1:0] OP_JR   = 5'd23;
  localparam logic [OP_W-1:0] OP_LI   = 5'd24;
  localparam logic [OP_W-1:0] OP_RC   = 5'd25;

  // Instruction format classes
  typedef enum logic [1:0] {
    CLS_R = 2'd0,
    CLS_I = 2'd1,
    CLS_L = 2'd2,
    CLS_N = 2'd3
  } fmt_class_e;

  // Session abort reasons
  localparam logic [ERR_W-1:0] ERR_NONE       = 2'd0;
  localparam logic [ERR_W-1:0] ERR_ILLEGAL_OP = 2'd1;
  localparam logic [ERR_W-1:0] ERR_IMM_RANGE  = 2'd2;
  localparam logic [ERR_W-1:0] ERR_ADDR_OVF   = 2'd3;

  // Largest immediate that fits the I-class 5-bit field
  localparam logic [IMM_W-1:0] IMM_I_MAX = 8'd31;

  // Symbolic instruction fields as delivered by the host
  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [IMM_W-1:0] imm;
  } inst_fields_t;

endpackage

// File: rtl/enc_format.sv
// Combinational field-to-word packer: classifies the opcode and builds the 16-bit instruction word.
module enc_format
  import inst_encoder_pkg::*;
(
  input  inst_fields_t            fields,
  output fmt_class_e              cls_c,
  output logic [INST_W-1:0]       word_c,
  output logic                    illegal_c,
  output logic                    imm_bad_c
);

  // Opcode classification; unknown opcodes are flagged and produce a zero word
  always_comb begin
    cls_c     = CLS_N;
    illegal_c = 1'b0;
    case (fields.op)
      OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR,
      OP_SLL, OP_SRL, OP_BEQ, OP_BLE:                    cls_c = CLS_R;
      OP_ADDI, OP_SUBI, OP_MULI, OP_ANDI, OP_ORI, OP_XORI,
      OP_SLLI, OP_SRLI, OP_LW, OP_SW, OP_CSRR, OP_CSRW:  cls_c = CLS_I;
      OP_JAL, OP_JR, OP_LI:                              cls_c = CLS_L;
      OP_RC:                                             cls_c = CLS_N;
      default:                                           illegal_c = 1'b1;
    endcase
  end

  // Immediate exceeds the I-class field; the caller qualifies it with the class
  assign imm_bad_c = (fields.imm > IMM_I_MAX);

  // Word packing per class, unused fields forced to zero
  always_comb begin
    word_c = '0;
    if (!illegal_c) begin
      case (cls_c)
        CLS_R:   word_c = {2'b00, fields.rt, fields.rs, fields.rd, fields.op};
        CLS_I:   word_c = {fields.imm[4:0], fields.rs, fields.rd, fields.op};
        CLS_L:   word_c = {fields.imm, fields.rd, fields.op};
        CLS_N:   word_c = {11'b0, fields.op};
        default: word_c = '0;
      endcase
    end
  end

endmodule

// File: rtl/inst_encoder.sv
// Program-loader encoder: accepts field bundles, checks and packs them, writes words to instruction RAM.
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [REG_W-1:0]  in_rs,
  input  logic [REG_W-1:0]  in_rt,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ERR_W-1:0]  err_code,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_e;

  state_e            state;
  logic [ADDR_W:0]   wr_ptr;
  inst_fields_t      fields;
  fmt_class_e        cls;
  logic [INST_W-1:0] word;
  logic              illegal;
  logic              imm_bad;

  assign fields = '{op: in_op, rd: in_rd, rs: in_rs, rt: in_rt, imm: in_imm};

  enc_format u_enc_format (
    .fields    (fields),
    .cls_c     (cls),
    .word_c    (word),
    .illegal_c (illegal),
    .imm_bad_c (imm_bad)
  );

  // Session FSM with write pointer, counter and all registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
      word_count <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        S_RUN: begin
          if (in_valid) begin
            if (illegal || ((cls == CLS_I) && imm_bad) || (wr_ptr >= DEPTH_L)) begin
              state    <= S_ERR;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              err      <= 1'b1;
              err_code <= illegal                   ? ERR_ILLEGAL_OP :
                          ((cls == CLS_I) && imm_bad) ? ERR_IMM_RANGE  : ERR_ADDR_OVF;
            end else begin
              mem_we     <= 1'b1;
              mem_addr   <= wr_ptr[ADDR_W-1:0];
              mem_wdata  <= DATA_W'(word);
              wr_ptr     <= wr_ptr + 1'b1;
              word_count <= word_count + 1'b1;
              if (in_last) begin
                state    <= S_DONE;
                in_ready <= 1'b0;
                busy     <= 1'b0;
                done     <= 1'b1;
              end
            end
          end
        end
        default: begin
          if (start) begin
            state      <= S_RUN;
            in_ready   <= 1'b1;
            busy       <= 1'b1;
            wr_ptr     <= {1'b0, base_addr};
            word_count <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed plus randomized bench for inst_encoder against a field-level reference model.
module tb_inst_encoder;
  import inst_encoder_pkg::*;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 256;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_op;
  logic [2:0]        in_rd, in_rs, in_rt;
  logic [7:0]        in_imm;
  logic              in_last;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              busy, done, err;
  logic [1:0]        err_code;
  logic [ADDR_W:0]   word_count;

  inst_encoder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
    .in_rs(in_rs), .in_rt(in_rt), .in_imm(in_imm), .in_last(in_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
    .done(done), .err(err), .err_code(err_code), .word_count(word_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit m_run, m_done, m_err;
  int m_code, m_ptr, m_count;

  // -1 illegal, 0 R, 1 I, 2 L, 3 N
  function automatic int op_class(input logic [4:0] op);
    if (op inside {OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_BEQ, OP_BLE})
      return 0;
    if (op inside {OP_ADDI, OP_SUBI, OP_MULI, OP_ANDI, OP_ORI, OP_XORI, OP_SLLI, OP_SRLI,
                   OP_LW, OP_SW, OP_CSRR, OP_CSRW})
      return 1;
    if (op inside {OP_JAL, OP_JR, OP_LI})
      return 2;
    if (op == OP_RC)
      return 3;
    return -1;
  endfunction

  function automatic int model_word(input int cls, input int op, input int rd, input int rs,
                                    input int rt, input int imm);
    case (cls)
      0:       return op + 32 * rd + 256 * rs + 2048 * rt;
      1:       return op + 32 * rd + 256 * rs + 2048 * (imm % 32);
      2:       return op + 32 * rd + 256 * imm;
      default: return op;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag);
    chk({tag, ".in_ready"},   32'(in_ready),   32'(m_run));
    chk({tag, ".busy"},       32'(busy),       32'(m_run));
    chk({tag, ".done"},       32'(done),       32'(m_done));
    chk({tag, ".err"},        32'(err),        32'(m_err));
    chk({tag, ".err_code"},   32'(err_code),   32'(m_code));
    chk({tag, ".word_count"}, 32'(word_count), 32'(m_count));
  endtask

  task automatic model_reset();
    m_run = 0; m_done = 0; m_err = 0; m_code = 0; m_ptr = 0; m_count = 0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ".mem_we"},    32'(mem_we),    32'd0);
    chk({tag, ".mem_addr"},  32'(mem_addr),  32'd0);
    chk({tag, ".mem_wdata"}, 32'(mem_wdata), 32'd0);
    check_status(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    step();
    step();
    model_reset();
    check_reset_values("reset");
    rst_n = 1'b1;
  endtask

  // start pulse; ignored by the model while a session is running
  task automatic pulse_start(input int base);
    start = 1'b1;
    base_addr = ADDR_W'(base);
    step();
    start = 1'b0;
    if (!m_run) begin
      m_run = 1; m_done = 0; m_err = 0; m_code = 0; m_ptr = base; m_count = 0;
    end
    chk("start.mem_we", 32'(mem_we), 32'd0);
    check_status("start");
  endtask

  // one offered bundle; in_valid stays high so calls can be back-to-back
  task automatic send(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs,
                      input logic [2:0] rt, input logic [7:0] imm, input bit last);
    int cls, code, exp_addr, exp_data;
    bit exp_we;
    in_op = op; in_rd = rd; in_rs = rs; in_rt = rt; in_imm = imm; in_last = last;
    in_valid = 1'b1;
    exp_we = 0; exp_addr = 0; exp_data = 0;
    cls = op_class(op);
    if (m_run) begin
      if (cls < 0)                    code = 1;
      else if (cls == 1 && imm > 31)  code = 2;
      else if (m_ptr >= int'(DEPTH))  code = 3;
      else                            code = 0;
      if (code != 0) begin
        m_run = 0; m_err = 1; m_code = code;
      end else begin
        exp_we = 1; exp_addr = m_ptr;
        exp_data = model_word(cls, int'(op), int'(rd), int'(rs), int'(rt), int'(imm));
        m_ptr++; m_count++;
        if (last) begin m_run = 0; m_done = 1; end
      end
    end
    step();
    chk("xfer.mem_we", 32'(mem_we), 32'(exp_we));
    if (exp_we) begin
      chk("xfer.mem_addr",  32'(mem_addr),  32'(exp_addr));
      chk("xfer.mem_wdata", 32'(mem_wdata), 32'(exp_data));
    end
    check_status("xfer");
  endtask

  task automatic idle();
    in_valid = 1'b0;
    step();
    chk("idle.mem_we", 32'(mem_we), 32'd0);
    check_status("idle");
  endtask

  initial begin
    base_addr = '0; in_op = '0; in_rd = '0; in_rs = '0; in_rt = '0; in_imm = '0;
    do_reset();

    // Two-word session with known words
    pulse_start(32'h10);
    send(OP_ADD, 3'd1, 3'd2, 3'd3, 8'd0, 1'b0);
    chk("add_word", 32'(mem_wdata), 32'h1A20 | 32'(OP_ADD));
    chk("add_addr", 32'(mem_addr), 32'h10);
    send(OP_ADDI, 3'd2, 3'd1, 3'd0, 8'd5, 1'b1);
    chk("addi_word", 32'(mem_wdata), 32'h2940 | 32'(OP_ADDI));
    chk("addi_done", 32'(done), 32'd1);
    chk("addi_count", 32'(word_count), 32'd2);
    idle();

    // L/N encodings then immediate out of range
    pulse_start(32'h20);
    send(OP_LI, 3'd3, 3'd7, 3'd5, 8'hA5, 1'b0);
    chk("li_word", 32'(mem_wdata), 32'hA560 | 32'(OP_LI));
    send(OP_RC, 3'd7, 3'd7, 3'd7, 8'hFF, 1'b0);
    chk("rc_word", 32'(mem_wdata), 32'(OP_RC));
    send(OP_ORI, 3'd1, 3'd1, 3'd0, 8'd32, 1'b0);
    chk("ori_err", 32'(err_code), 32'd2);
    idle();

    // Illegal opcode, then restart clears the error
    pulse_start(32'h00);
    send(5'd31, 3'd0, 3'd0, 3'd0, 8'd0, 1'b0);
    chk("illegal_code", 32'(err_code), 32'd1);
    idle();
    pulse_start(32'h05);
    chk("restart_err", 32'(err), 32'd0);
    send(OP_AND, 3'd4, 3'd5, 3'd6, 8'd0, 1'b1);
    idle();

    // Last legal address then overflow
    pulse_start(DEPTH - 1);
    send(OP_SUB, 3'd1, 3'd1, 3'd1, 8'd0, 1'b0);
    chk("top_addr", 32'(mem_addr), 32'(DEPTH - 1));
    send(OP_XOR, 3'd2, 3'd2, 3'd2, 8'd0, 1'b0);
    chk("ovf_code", 32'(err_code), 32'd3);
    idle();

    // start with in_valid high from ERR: start wins, no transfer
    in_op = OP_ADD; in_last = 1'b0; in_valid = 1'b1;
    pulse_start(32'h30);
    send(OP_ADD, 3'd1, 3'd0, 3'd0, 8'd0, 1'b0);
    send(OP_SLLI, 3'd2, 3'd3, 3'd0, 8'd31, 1'b0);
    send(OP_JAL, 3'd4, 3'd0, 3'd0, 8'd200, 1'b0);
    send(OP_BLE, 3'd5, 3'd6, 3'd7, 8'd0, 1'b1);
    idle();

    // start ignored while running
    pulse_start(32'h40);
    pulse_start(32'h80);
    send(OP_MUL, 3'd1, 3'd2, 3'd3, 8'd0, 1'b1);
    chk("run_start_addr", 32'(mem_addr), 32'h40);
    idle();

    // Reset during the third word of a stream
    pulse_start(32'h50);
    send(OP_OR, 3'd1, 3'd1, 3'd1, 8'd0, 1'b0);
    send(OP_SW, 3'd2, 3'd2, 3'd0, 8'd9, 1'b0);
    in_op = OP_LW; in_imm = 8'd3; rst_n = 1'b0;
    step();
    model_reset();
    check_reset_values("midreset");
    rst_n = 1'b1; in_valid = 1'b0;
    step();

    // Randomized sessions
    for (int s = 0; s < 25; s++) begin
      int n, base;
      n = int'($urandom_range(1, 8));
      base = ($urandom_range(0, 3) == 0) ? int'($urandom_range(DEPTH - 4, DEPTH - 1))
                                          : int'($urandom_range(0, DEPTH - 1));
      pulse_start(base);
      for (int k = 0; k < n; k++) begin
        logic [7:0] imm;
        imm = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 31));
        send(5'($urandom_range(0, 31)), 3'($urandom), 3'($urandom), 3'($urandom), imm, k == n - 1);
      end
      idle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Program-loader encoder for the 16-bit MoonCore pipeline. It is the inverse of the ID-stage decoder. It accepts symbolic instruction fields (opcode, rd, rs, rt, immediate) over a valid/ready stream, checks them against the instruction formats, and packs them into 16-bit instruction words. It then writes the words at consecutive addresses into the instruction memory write port. It sits between the debug/UART host path and the instruction RAM, and runs while the core is held off.

## Interface
Parameters:
- `DATA_W`, 16: instruction width. Must equal `CPU_WIDTH`.
- `ADDR_W`, 8: instruction memory address width.
- `DEPTH`, 256: number of instruction memory words. Must be ≤ 2^ADDR_W.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  one-cycle pulse that begins a load session. Ignored in RUN.
- `base_addr`  in  ADDR_W  first write address. Sampled on `start`.
- `in_valid`  in  1  field bundle valid.
- `in_ready`  out  1  encoder can accept.
- `in_op`  in  5  opcode, using the para.v opcode defines.
- `in_rd`, `in_rs`, `in_rt`  in  3 each  register fields.
- `in_imm`  in  8  unsigned immediate.
- `in_last`  in  1  final instruction of the session.
- `mem_we`  out  1  instruction memory write strobe.
- `mem_addr`  out  ADDR_W  write address.
- `mem_wdata`  out  DATA_W  encoded instruction.
- `busy`  out  1  state is RUN.
- `done`  out  1  session ended cleanly. Held until the next `start`.
- `err`  out  1  session aborted. Held until the next `start`.
- `err_code`  out  2  0 none, 1 illegal opcode, 2 immediate out of range, 3 address overflow.
- `word_count`  out  ADDR_W+1  number of words written this session.

## Operation
- States: IDLE, RUN, DONE, ERR.
- IDLE, DONE and ERR transition to RUN on `start`. On that transition: `wr_ptr` ← `base_addr`; `word_count`, `done`, `err` and `err_code` are cleared.
- `in_ready` = 1 only in RUN. The transfer occurs when `in_valid & in_ready`.
- Format classes:
  - R: ADD, SUB, MUL, AND, OR, XOR, SLL, SRL, BEQ, BLE. Word = {2'b0, rt, rs, rd, op}.
  - I: ADDI, SUBI, MULI, ANDI, ORI, XORI, SLLI, SRLI, LW, SW, CSRR, CSRW. Word = {imm[4:0], rs, rd, op}. Requires imm ≤ 31.
  - L: JAL, JR, LI. Word = {imm[7:0], rd, op}. `in_rs` and `in_rt` are ignored.
  - N: RC. Word = {11'b0, op}.
- Unused fields are always encoded as zero.
- Checks on each transfer, in priority order:
  - Opcode in no class → code 1.
  - I-class with imm > 31 → code 2.
  - `wr_ptr` ≥ DEPTH → code 3.
- On any error, no write occurs and the state goes to ERR.
- On a clean transfer: the word is registered and written, `wr_ptr` increments, and `word_count` increments. If `in_last` is set, the state goes to DONE. Otherwise it stays in RUN.
- `wr_ptr` does not wrap. Writing address DEPTH-1 is legal; the next transfer raises code 3.

## Timing
- Throughput is one instruction per cycle in RUN.
- Latency: for a transfer at edge N, `mem_we` = 1 for the cycle after edge N. `mem_addr` and `mem_wdata` are valid in that same cycle.
- When the last word is transferred at edge N, the state is DONE and `done` = 1 in the same cycle as its `mem_we`. `word_count` is already updated in that cycle.
- `err` and `err_code` are registered at the erroring edge. `mem_we` = 0 in that cycle. Words written before the error remain in memory.
- `start` in the same cycle as a transfer in DONE/ERR: `start` wins, and there is no transfer because `in_ready` = 0.
- Reset values: state IDLE, `in_ready` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, `busy` 0, `done` 0, `err` 0, `err_code` 0, `word_count` 0.
- Reset asserted mid-session drops any pending write: `mem_we` = 0 at the next edge.

## Structure
- Add to para.v:
  - the class encodings (R/I/L/N), 2 bits;
  - the err_code constants;
  - the I-class immediate limit of 31.
  Opcodes are reused from the existing para.v defines.
- Sub-module `enc_format`: purely combinational. Maps (op, rd, rs, rt, imm) to {class, word, illegal, imm_bad}. The top level holds the FSM, pointer, counter and output registers.

## Test plan
- Session base 0x10 with ADD rd=1 rs=2 rt=3, then ADDI rd=2 rs=1 imm=5 with `in_last` → writes 0x1A20|`ADD at 0x10 and 0x2940|`ADDI at 0x11; `done` = 1 with the second `mem_we`; `word_count` = 2.
- LI rd=3 imm=0xA5 with `in_rs` = 7 → `mem_wdata` = 0xA560|`LI (rs ignored). RC → 0x0000|`RC.
- ORI with imm = 32 as the third word → two writes, then `err` = 1, `err_code` = 2, no third `mem_we`, `in_ready` = 0.
- Undefined opcode → `err_code` = 1, no write. A following `start` clears `err`/`err_code` and accepts again.
- Base = DEPTH-1, two instructions → first written at DEPTH-1; second gives `err_code` = 3.
- Back-to-back `in_valid` for 4 words → 4 consecutive `mem_we` cycles. Reset asserted during the third word → `mem_we` 0 at the next edge, all outputs at reset values.
